// File: rtl/truth_table_scanner.sv
// Sequential truth-table extractor: sweeps every input combination, records f_a's minterms and ones count,
// and checks f_a against f_b. Optional macro SCAN_STOP_ON_DIFF_EN ends the scan at the first mismatch.
module truth_table_scanner #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N-1:0]    vars,
    input  logic            f_a,
    input  logic            f_b,
    output logic            busy,
    output logic            done,
    output logic [2**N-1:0] minterms,
    output logic [N:0]      ones_cnt,
    output logic            equal,
    output logic [N-1:0]    first_diff
);

    localparam int          M        = 2**N;
    localparam logic [N-1:0] LAST_IDX = N'(M - 1);
    localparam logic [3:0]  CNT_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   vars_q, vars_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [M-1:0]   minterms_q, minterms_d;
    logic [N:0]     ones_q, ones_d;
    logic           equal_q, equal_d;
    logic [N-1:0]   first_diff_q, first_diff_d;
    logic           mismatch;
    logic           stop_scan;

    assign mismatch = (f_a != f_b);

`ifdef SCAN_STOP_ON_DIFF_EN
    assign stop_scan = (idx_q == LAST_IDX) || mismatch;
`else
    assign stop_scan = (idx_q == LAST_IDX);
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        vars_d       = vars_q;
        minterms_d   = minterms_q;
        ones_d       = ones_q;
        equal_d      = equal_q;
        first_diff_d = first_diff_q;
        case (state_q)
            IDLE: begin
                // Previous results stay visible until the next scan clears them here.
                if (start) begin
                    state_d      = APPLY;
                    idx_d        = '0;
                    vars_d       = '0;
                    cnt_d        = '0;
                    minterms_d   = '0;
                    ones_d       = '0;
                    equal_d      = 1'b1;
                    first_diff_d = '0;
                end
            end
            APPLY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                minterms_d[idx_q] = f_a;
                ones_d            = ones_q + {{N{1'b0}}, f_a};
                if (mismatch && equal_q) begin
                    equal_d      = 1'b0;
                    first_diff_d = idx_q;
                end
                if (stop_scan) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    vars_d  = idx_q + 1'b1;
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == APPLY) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            vars_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            minterms_q   <= '0;
            ones_q       <= '0;
            equal_q      <= 1'b0;
            first_diff_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            vars_q       <= vars_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            minterms_q   <= minterms_d;
            ones_q       <= ones_d;
            equal_q      <= equal_d;
            first_diff_q <= first_diff_d;
        end
    end

    assign vars       = vars_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign minterms   = minterms_q;
    assign ones_cnt   = ones_q;
    assign equal      = equal_q;
    assign first_diff = first_diff_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: expectations are queued at start, monitors check on done.
module tb_truth_table_scanner;

    typedef struct {
        logic [15:0] mt;
        int          ones;
        logic        eq;
        int          fd;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start3;
    logic [3:0]  vars, vars3;
    logic        fa, fb;
    logic        fa3, fb3;
    logic        busy, done, equal;
    logic        busy3, done3, equal3;
    logic [15:0] minterms, minterms3;
    logic [4:0]  ones_cnt, ones_cnt3;
    logic [3:0]  first_diff, first_diff3;
    logic [1:0]  mode;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t q3[$];

    truth_table_scanner #(.N(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vars(vars), .f_a(fa), .f_b(fb),
        .busy(busy), .done(done), .minterms(minterms), .ones_cnt(ones_cnt),
        .equal(equal), .first_diff(first_diff)
    );

    truth_table_scanner #(.N(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .vars(vars3), .f_a(fa3), .f_b(fb3),
        .busy(busy3), .done(done3), .minterms(minterms3), .ones_cnt(ones_cnt3),
        .equal(equal3), .first_diff(first_diff3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Functions under test, selected by mode; dut3 sees the all-ones function.
    always_comb begin
        fa  = 1'b1;
        fb  = 1'b1;
        fa3 = 1'b1;
        fb3 = 1'b1;
        case (mode)
            2'd0: begin fa = ~vars[0]; fb = ~vars[0]; end
            2'd1: begin fa = vars[0];  fb = vars[0];  end
            2'd2: begin fa = ~^vars;   fb = (~^vars) ^ ((vars == 4'd6) || (vars == 4'd9)); end
            default: begin fa = 1'b1;  fb = 1'b1;     end
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("minterms", int'(minterms), int'(e.mt));
                chk("ones_cnt", int'(ones_cnt), e.ones);
                chk("equal", int'(equal), int'(e.eq));
                chk("first_diff", int'(first_diff), e.fd);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (done3) begin
            if (q3.size() == 0) begin
                chk("unexpected_done3", 1, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("done3_cycle", cyc, e.due);
                chk("minterms3", int'(minterms3), int'(e.mt));
                chk("ones_cnt3", int'(ones_cnt3), e.ones);
                chk("equal3", int'(equal3), int'(e.eq));
            end
        end
    end

    task automatic push(input logic [15:0] mt, input int ones, input logic eq, input int fd, input int lat);
        exp_t e;
        e.mt = mt; e.ones = ones; e.eq = eq; e.fd = fd; e.due = cyc + 1 + lat;
        q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == budget) chk({name, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        mode   = 2'd0;
        #1;
        chk("rst_vars", int'(vars), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_minterms", int'(minterms), 0);
        chk("rst_ones", int'(ones_cnt), 0);
        chk("rst_equal", int'(equal), 0);
        chk("rst_first_diff", int'(first_diff), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Complement of z
        mode = 2'd0;
        push(16'h5555, 8, 1'b1, 0, 32);
        pulse_start();
        chk("busy_running", int'(busy), 1);
        wait_done("t1", 60);

        // z itself
        mode = 2'd1;
        push(16'hAAAA, 8, 1'b1, 0, 32);
        pulse_start();
        wait_done("t2", 60);

        // XNOR with B flipped at 6 and 9
        mode = 2'd2;
`ifdef SCAN_STOP_ON_DIFF_EN
        push(16'h0069, 4, 1'b0, 6, 14);
`else
        push(16'h9669, 8, 1'b0, 6, 32);
`endif
        pulse_start();
        wait_done("t3", 60);

        // Reset mid-scan: nothing queued, so any done pulse is flagged
        mode = 2'd1;
        pulse_start();
        begin
            int i;
            for (i = 0; i < 40; i++) begin
                if (vars == 4'd5) break;
                @(negedge clk);
            end
            if (i == 40) chk("wait_vars5_timeout", 0, 1);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_vars", int'(vars), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_minterms", int'(minterms), 0);
        chk("abort_ones", int'(ones_cnt), 0);
        chk("abort_equal", int'(equal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push(16'hAAAA, 8, 1'b1, 0, 32);
        pulse_start();
        wait_done("t4", 60);

        // Start held high: retrigger only after DONE -> IDLE
        mode = 2'd0;
        push(16'h5555, 8, 1'b1, 0, 32);
        push(16'h5555, 8, 1'b1, 0, 66);
        start = 1'b1;
        wait_done("t5a", 60);
        repeat (6) @(negedge clk);
        chk("held_busy_second", int'(busy), 1);
        start = 1'b0;
        wait_done("t5b", 60);
        repeat (4) @(negedge clk);
        chk("held_idle_after", int'(busy), 0);

        // SETTLE=3 with the all-ones function
        begin
            exp_t e;
            e.mt = 16'hFFFF; e.ones = 16; e.eq = 1'b1; e.fd = 0; e.due = cyc + 1 + 64;
            q3.push_back(e);
        end
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        begin
            int i;
            for (i = 0; i < 120; i++) begin
                @(negedge clk);
                if (done3) break;
            end
            if (i == 120) chk("t6_timeout", 0, 1);
        end
        repeat (3) @(negedge clk);

        chk("queue_drained", q.size(), 0);
        chk("queue3_drained", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
